// File: rtl/fetch_queue.sv
// fetch_queue: PC register plus a DEPTH-entry {pc, instr} FIFO between the
// combinational instruction memory and the issue stage.
//
// Ports:
//   clk, reset        clock and asynchronous active-low reset
//   fetch_en          allows a fetch in this cycle
//   imem_addr         instruction memory address (the current PC)
//   imem_rdata        instruction read combinationally from imem_addr
//   stall             per-reservation-station stall; any bit set blocks issue
//   redirect_valid    flush the queue and restart fetch at redirect_pc
//   redirect_pc       new fetch PC, used verbatim
//   issue_valid       head entry is valid
//   issue_pc          PC of the head entry (0 when empty)
//   issue_instr       instruction of the head entry (0 when empty)
//   count             number of occupied entries
//   full              count == DEPTH
module fetch_queue #(
    parameter int unsigned   XLEN     = 32,
    parameter int unsigned   DEPTH    = 4,
    parameter int unsigned   N_STALL  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fetch_en,
    output logic [XLEN-1:0]              imem_addr,
    input  logic [XLEN-1:0]              imem_rdata,
    input  logic [N_STALL-1:0]           stall,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic                         issue_valid,
    output logic [XLEN-1:0]              issue_pc,
    output logic [XLEN-1:0]              issue_instr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pop_c;
    logic               push_c;
    entry_t             head_c;

    // Handshake decode; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        pop_c  = (count_q != '0) && !(|stall);
        push_c = fetch_en && !redirect_valid
                 && ((count_q != CNT_W'(DEPTH)) || pop_c);
    end

    // Next-state for PC, pointers and occupancy; redirect overrides push/pop.
    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                pc_d     = XLEN'(pc_q + XLEN'(4));
                wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(1));
            end
            if (pop_c) begin
                rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
            end
            if (push_c && !pop_c) begin
                count_d = CNT_W'(count_q + CNT_W'(1));
            end else if (pop_c && !push_c) begin
                count_d = CNT_W'(count_q - CNT_W'(1));
            end
        end
    end

    // Control state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: the head view is masked while empty.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= '{pc: pc_q, instr: imem_rdata};
        end
    end

    always_comb begin
        head_c      = mem_q[rd_ptr_q];
        imem_addr   = pc_q;
        issue_valid = (count_q != '0);
        issue_pc    = issue_valid ? head_c.pc    : '0;
        issue_instr = issue_valid ? head_c.instr : '0;
        count       = count_q;
        full        = (count_q == CNT_W'(DEPTH));
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised fetch front end that replaces the bare PC register in front of the Tomasulo core.
- Holds the PC, drives the combinational instruction memory and buffers fetched {pc, instr} pairs in a DEPTH-entry FIFO.
- The issue stage drains the FIFO when none of N_STALL reservation-station stall lines is asserted; the old design had only two such lines, A and LS.
- Adds things the old PC logic lacked: decoupling between fetch and issue, redirect with queue flush, and a fetch enable.

Parameters:
- XLEN, 32, width of the PC and the instruction.
- DEPTH, 4, number of FIFO entries; a power of two, at least 2.
- N_STALL, 2, number of stall inputs from the reservation stations.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_en  in  1  allows fetch when 1.
- imem_addr  out  XLEN  instruction memory address; always equals the PC.
- imem_rdata  in  XLEN  instruction read combinationally from imem_addr in the same cycle.
- stall  in  N_STALL  per-station stall; any bit set blocks issue.
- redirect_valid  in  1  flush-and-redirect request (branch or jump resolution).
- redirect_pc  in  XLEN  new fetch PC.
- issue_valid  out  1  head entry is valid.
- issue_pc  out  XLEN  PC of the head entry.
- issue_instr  out  XLEN  instruction of the head entry.
- count  out  $clog2(DEPTH+1)  number of occupied entries.
- full  out  1  count == DEPTH.

Behaviour:
- Reset (reset=0, asynchronous, any cycle, including mid-redirect):
  - PC = RESET_PC; read and write pointers = 0; count = 0.
  - issue_valid = 0, full = 0.
  - issue_pc = 0, issue_instr = 0.
- Storage: circular buffer with log2(DEPTH)-bit pointers that wrap from DEPTH-1 to 0, plus a separate occupancy counter.
- Head outputs are registered-state views:
  - issue_valid = (count != 0).
  - issue_pc and issue_instr read the entry at the read pointer.
  - When empty, issue_pc and issue_instr are forced to 0.
- pop = issue_valid & ~|stall. A pop advances the read pointer. The entry is consumed in the cycle pop is high.
- push = fetch_en & ~redirect_valid & (~full | pop).
  - A push writes {PC, imem_rdata} at the write pointer, advances the write pointer and sets PC <= PC + 4. The sum wraps modulo 2^XLEN.
  - When full, a push is allowed only in the same cycle as a pop. Count then stays at DEPTH.
  - No push when fetch_en = 0; PC holds.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
  - Count never exceeds DEPTH and never goes below 0.
- Redirect (redirect_valid = 1) has priority over push and pop:
  - Next cycle: read pointer = write pointer = 0, count = 0, PC = redirect_pc.
  - No entry is written that cycle.
  - issue_valid may be 1 in the redirect cycle, but the issue stage must ignore it. The fetch queue does not count that as a pop.
  - First fetch from redirect_pc occurs the following cycle. Its entry is visible at the head one cycle after that.
- Latency:
  - An instruction fetched in cycle t appears at issue_valid in cycle t+1 (empty queue, no stall).
  - Sustained throughput is 1 instruction per cycle.
- Stall:
  - Any stall bit set holds the head stable: issue_pc and issue_instr unchanged.
  - Fetch continues until full, then PC holds.
- Simultaneous redirect and stall: the redirect wins and the queue flushes.
- Alignment: imem_addr low 2 bits are never modified by the block. redirect_pc is used verbatim.

Test Plan:
- Reset release, RESET_PC = 0, fetch_en = 1, no stall, imem returning addr ^ 32'hA5A5_0000:
  - Cycle 1: issue_valid = 1, issue_pc = 0.
  - Consecutive cycles: issue_pc = 0, 4, 8, 12, and count stays at 1.
- stall = 2'b01 held for 6 cycles from the first fetch, DEPTH = 4:
  - count rises 1, 2, 3, 4; full = 1; imem_addr holds at 16.
  - issue_pc stays 0.
  - After the stall is released: one pop and one push per cycle; count stays 4; issue_pc steps 0, 4, 8, and so on.
- Full queue with both stall bits cleared in the same cycle as fetch: the simultaneous push and pop leave count = 4, the write pointer wraps to 0 and the entries stay in order.
- redirect_valid = 1, redirect_pc = 0x100, with 3 entries queued:
  - Next cycle: count = 0, issue_valid = 0, imem_addr = 0x100.
  - Following cycle: issue_pc = 0x100.
- redirect_valid together with stall = 2'b11 on a full queue: the flush still occurs and PC = redirect_pc.
- Assert reset = 0 mid-stream with count = 3 and PC = 0x40:
  - Without waiting for an edge: count = 0, issue_valid = 0, imem_addr = RESET_PC.
  - fetch_en = 0 after release: PC holds and count stays 0.
